// File: rtl/imem_loader.sv
// UART (8N1) program loader: packs received bytes big-endian into 32-bit words,
// writes them to instruction memory and holds the CPU in reset until a HALT word lands.
module imem_loader #(
    parameter int CLKS_PER_BIT = 16,
    parameter int ADDR_WIDTH   = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_rst_n,
    output logic                  busy,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   word_count
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
    typedef enum logic [1:0] {LOAD, DONE, ERROR} ld_state_t;

    logic                  r_rx_meta, r_rx_sync;
    rx_state_t             r_rx_state;
    logic [CW-1:0]         r_cnt;
    logic [2:0]            r_bit;
    logic [7:0]            r_shift;
    ld_state_t             r_ld_state;
    logic [1:0]            r_lane;
    logic [23:0]           r_word;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_wdata;
    logic                  r_pend;
    logic                  r_cpu_rst_n;
    logic                  r_busy;
    logic                  r_error;
    logic [ADDR_WIDTH:0]   r_wcount;

    logic w_load, w_stop_hit, w_byte_ok, w_frame_err, w_start_ok;

    assign w_load      = (r_ld_state == LOAD);
    assign w_stop_hit  = (r_rx_state == STOP) && (r_cnt == BIT_LAST);
    assign w_byte_ok   = w_stop_hit && r_rx_sync;
    assign w_frame_err = w_stop_hit && !r_rx_sync;
    assign w_start_ok  = (r_rx_state == START) && (r_cnt == HALF_LAST) && !r_rx_sync;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    // Receiver is parked in IDLE once the loader has finished, so rx is ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_state <= IDLE;
            r_cnt      <= '0;
            r_bit      <= '0;
            r_shift    <= '0;
        end else if (!w_load) begin
            r_rx_state <= IDLE;
            r_cnt      <= '0;
        end else begin
            case (r_rx_state)
                IDLE: begin
                    r_cnt <= '0;
                    if (!r_rx_sync) r_rx_state <= START;
                end
                START: begin
                    if (r_cnt == HALF_LAST) begin
                        r_cnt      <= '0;
                        r_bit      <= '0;
                        r_rx_state <= r_rx_sync ? IDLE : DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (r_cnt == BIT_LAST) begin
                        r_cnt   <= '0;
                        r_shift <= {r_rx_sync, r_shift[7:1]};
                        if (r_bit == 3'd7) r_rx_state <= STOP;
                        else               r_bit      <= r_bit + 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (r_cnt == BIT_LAST) begin
                        r_cnt      <= '0;
                        r_rx_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_rx_state <= IDLE;
            endcase
        end
    end

    // r_pend marks the cycle after a write: count, HALT and overflow are resolved there.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ld_state  <= LOAD;
            r_lane      <= '0;
            r_word      <= '0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_pend      <= 1'b0;
            r_cpu_rst_n <= 1'b0;
            r_busy      <= 1'b0;
            r_error     <= 1'b0;
            r_wcount    <= '0;
        end else begin
            r_we <= 1'b0;
            case (r_ld_state)
                LOAD: begin
                    if (w_start_ok) r_busy <= 1'b1;
                    if (r_pend) begin
                        r_pend   <= 1'b0;
                        r_wcount <= r_wcount + 1'b1;
                        if (r_wdata[31:26] == 6'd63) begin
                            r_ld_state  <= DONE;
                            r_cpu_rst_n <= 1'b1;
                            r_busy      <= 1'b0;
                        end else if (&r_addr) begin
                            r_ld_state <= ERROR;
                            r_error    <= 1'b1;
                            r_busy     <= 1'b0;
                        end
                    end else if (w_frame_err) begin
                        r_ld_state <= ERROR;
                        r_error    <= 1'b1;
                        r_busy     <= 1'b0;
                    end else if (w_byte_ok) begin
                        r_lane <= r_lane + 2'd1;
                        case (r_lane)
                            2'd0: r_word[23:16] <= r_shift;
                            2'd1: r_word[15:8]  <= r_shift;
                            2'd2: r_word[7:0]   <= r_shift;
                            default: begin
                                r_we    <= 1'b1;
                                r_addr  <= r_wcount[ADDR_WIDTH-1:0];
                                r_wdata <= {r_word, r_shift};
                                r_pend  <= 1'b1;
                            end
                        endcase
                    end
                end
                DONE:    r_ld_state <= DONE;
                ERROR:   r_ld_state <= ERROR;
                default: r_ld_state <= ERROR;
            endcase
        end
    end

    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign cpu_rst_n  = r_cpu_rst_n;
    assign busy       = r_busy;
    assign error      = r_error;
    assign word_count = r_wcount;
endmodule

// File: doc/imem_loader.md
# imem_loader

Serial program loader sitting upstream of the CPU's instruction memory. It receives a program over a UART line (8N1) and packs the bytes big-endian into 32-bit words. It writes each word into instruction memory through a dedicated write port, then holds the CPU in reset until a HALT word (opcode 63) has been stored. When that happens it releases the CPU, which starts fetching at pc 0.

## Interface
- CLKS_PER_BIT, 16: clk cycles per UART bit; even, ≥ 4.
- ADDR_WIDTH, 10: instruction memory word-address width (1024 words).

- clk  in  1  system clock.
- rst  in  1  reset: asynchronous, active-low.
- rx  in  1  UART serial input, idle high, asynchronous to clk.
- imem_we  out  1  one-cycle write strobe to instruction memory.
- imem_addr  out  ADDR_WIDTH  word address of the current write.
- imem_wdata  out  32  word being written.
- cpu_rst_n  out  1  active-low reset to the CPU; high only after a successful load.
- busy  out  1  load in progress.
- error  out  1  sticky fault (framing or overflow).
- word_count  out  ADDR_WIDTH+1  number of words written.

## Operation
- rx passes through a 2-flop synchronizer. All references to rx below mean the synchronized value.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START when rx = 0.
  - START: samples at CLKS_PER_BIT/2. If rx = 1 (glitch), the FSM returns to IDLE without signalling anything. Otherwise it goes to DATA.
  - DATA: 8 bits, LSB first, one sample every CLKS_PER_BIT.
  - STOP: samples once. rx = 1 yields a valid byte. rx = 0 is a framing error.
- Loader FSM states: LOAD, DONE, ERROR.
  - LOAD: a 2-bit lane counter places byte 0 in [31:24], byte 1 in [23:16], byte 2 in [15:8], byte 3 in [7:0]. On the 4th byte it pulses imem_we with imem_addr = word index, increments the index and word_count, and resets the lane counter.
  - LOAD -> DONE when the written word has [31:26] = 6'd63.
  - LOAD -> ERROR on a framing error.
  - LOAD -> ERROR when a non-HALT word is written at address 2^ADDR_WIDTH−1 (overflow).
  - DONE and ERROR are terminal until rst. In both states rx is ignored and imem_we is never asserted.
- cpu_rst_n = 1 only in DONE.
- error = 1 only in ERROR.
- busy = 1 from the first start-bit detection until DONE or ERROR.
- A partial word (fewer than 4 bytes) is never written.
- imem_addr and imem_wdata hold their last values when imem_we = 0.

## Timing
- Reset values: imem_we 0, imem_addr 0, imem_wdata 0, cpu_rst_n 0, busy 0, error 0, word_count 0. All FSMs go to IDLE/LOAD and the lane counter to 0.
- rst is asynchronous and effective mid-byte or mid-word. Partial bytes and words are discarded, and the next load starts at address 0.
- Synchronizer latency is 2 cycles from pin to FSM.
- Let S be the cycle in which the FSM first sees rx = 0. Samples are taken at:
  - start bit: S + CLKS_PER_BIT/2;
  - data bit k (k = 0..7): S + CLKS_PER_BIT/2 + (k+1)·CLKS_PER_BIT;
  - stop bit: S + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT (call this cycle T).
- After the stop sample the RX FSM returns to IDLE at T+1 and can detect the next start bit in the same cycle.
- For the 4th byte of a word:
  - imem_we = 1 during cycle T+1 only;
  - imem_addr and imem_wdata are valid in that cycle;
  - word_count updates at T+2.
- HALT word: cpu_rst_n rises at T+2 and busy falls at T+2.
- Framing error at T: error rises at T+1, and no write occurs for that word.
- Overflow: error rises at T+2, the cycle after the final write.
- Back-to-back bytes with zero idle time between stop and next start are supported.

## Test plan
- Load 04 00 00 05, then FC 00 00 00:
  - writes addr 0 = 0x04000005, then addr 1 = 0xFC000000;
  - each imem_we lasts exactly 1 cycle;
  - cpu_rst_n = 1, word_count = 2, busy = 0, error = 0.
- Glitch: rx low for CLKS_PER_BIT/4 cycles, then high -> no byte, no write, busy stays 0, FSM is in IDLE.
- Framing error: byte 0x12 with stop bit 0 -> error = 1, cpu_rst_n = 0. Subsequent valid bytes FC 00 00 00 produce no imem_we.
- Overflow with ADDR_WIDTH = 2: four words 0x00000001..0x00000004 -> writes at addrs 0..3, then error = 1, cpu_rst_n = 0, word_count = 4.
- Reset mid-operation: send 2 bytes, assert rst during the 3rd byte's DATA phase, release, then load FC 00 00 00 -> a single write at addr 0 = 0xFC000000, cpu_rst_n = 1.
- Bytes after DONE: after a HALT load, send 8 more bytes -> no imem_we, word_count unchanged, cpu_rst_n stays 1.
